// File: rtl/snake_defs.sv
// ============================================================================
// Module  : snake_defs
// Brief   : Shared widths, tile geometry and FSM encoding for the snake game.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package snake_defs;

  localparam int BIT       = 10;
  localparam int MAX_LEN   = 16;
  localparam int IDX_W     = 4;
  localparam int TILE_LOG2 = 4;
  localparam int MAX_RETRY = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRIG  = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
  localparam logic [1:0] ST_SCAN  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/food_placer.sv
// ============================================================================
// Module  : food_placer
// Brief   : Draws tile-aligned food candidates from random_position and
//           rejects any that land on the snake body, retrying a bounded number
//           of times before committing anyway.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module food_placer #(
  parameter int BIT       = snake_defs::BIT,
  parameter int MAX_LEN   = snake_defs::MAX_LEN,
  parameter int IDX_W     = snake_defs::IDX_W,
  parameter int TILE_LOG2 = snake_defs::TILE_LOG2,
  parameter int MAX_RETRY = snake_defs::MAX_RETRY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             place_req,
  input  logic [IDX_W:0]   snake_len,
  output logic [IDX_W-1:0] seg_idx,
  input  logic [BIT-1:0]   seg_x,
  input  logic [BIT-1:0]   seg_y,
  output logic             rng_trigger,
  input  logic [BIT-1:0]   rng_x,
  input  logic [BIT-1:0]   rng_y,
  output logic [BIT-1:0]   food_x,
  output logic [BIT-1:0]   food_y,
  output logic             food_valid,
  output logic             busy,
  output logic             placed,
  output logic             place_fail
);

  import snake_defs::*;

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [IDX_W:0]     LEN_MAX   = (IDX_W + 1)'(MAX_LEN);

  logic [1:0]         state_q,       state_d;
  logic [BIT-1:0]     cand_x_q,      cand_x_d;
  logic [BIT-1:0]     cand_y_q,      cand_y_d;
  logic [BIT-1:0]     food_x_q,      food_x_d;
  logic [BIT-1:0]     food_y_q,      food_y_d;
  logic               food_valid_q,  food_valid_d;
  logic               placed_q,      placed_d;
  logic               place_fail_q,  place_fail_d;
  logic               rng_trigger_q, rng_trigger_d;
  logic [IDX_W-1:0]   seg_idx_q,     seg_idx_d;
  logic [RETRY_W-1:0] retry_q,       retry_d;

  logic [IDX_W:0] len_clamped;
  logic [IDX_W:0] last_idx;
  logic           hit;
  logic           at_last;
  logic           commit;
  logic           force_fail;

  // Low tile bits are discarded by the alignment.
  logic unused_rng_lsbs;
  assign unused_rng_lsbs = ^{rng_x[TILE_LOG2-1:0], rng_y[TILE_LOG2-1:0]};

  always_comb begin
    len_clamped = (snake_len > LEN_MAX) ? LEN_MAX : snake_len;
    last_idx    = len_clamped - (IDX_W + 1)'(1);
    hit         = (seg_x == cand_x_q) && (seg_y == cand_y_q);
    at_last     = ({1'b0, seg_idx_q} == last_idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cand_x_q      <= '0;
      cand_y_q      <= '0;
      food_x_q      <= '0;
      food_y_q      <= '0;
      food_valid_q  <= 1'b0;
      placed_q      <= 1'b0;
      place_fail_q  <= 1'b0;
      rng_trigger_q <= 1'b0;
      seg_idx_q     <= '0;
      retry_q       <= '0;
    end else begin
      state_q       <= state_d;
      cand_x_q      <= cand_x_d;
      cand_y_q      <= cand_y_d;
      food_x_q      <= food_x_d;
      food_y_q      <= food_y_d;
      food_valid_q  <= food_valid_d;
      placed_q      <= placed_d;
      place_fail_q  <= place_fail_d;
      rng_trigger_q <= rng_trigger_d;
      seg_idx_q     <= seg_idx_d;
      retry_q       <= retry_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    seg_idx_d    = seg_idx_q;
    retry_d      = retry_q;
    food_valid_d = food_valid_q;
    commit       = 1'b0;
    force_fail   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (place_req) begin
          state_d      = ST_TRIG;
          food_valid_d = 1'b0;
          retry_d      = '0;
        end
      end
      ST_TRIG: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        // random_position already updated on the TRIG edge.
        cand_x_d  = {rng_x[BIT-1:TILE_LOG2], {TILE_LOG2{1'b0}}};
        cand_y_d  = {rng_y[BIT-1:TILE_LOG2], {TILE_LOG2{1'b0}}};
        seg_idx_d = '0;
        if (len_clamped == '0) begin
          commit = 1'b1;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hit) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_TRIG;
          end else begin
            commit     = 1'b1;
            force_fail = 1'b1;
          end
        end else if (at_last) begin
          commit = 1'b1;
        end else begin
          seg_idx_d = seg_idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (commit) begin
      state_d      = ST_IDLE;
      food_valid_d = 1'b1;
    end

    food_x_d      = commit ? cand_x_d : food_x_q;
    food_y_d      = commit ? cand_y_d : food_y_q;
    placed_d      = commit;
    place_fail_d  = force_fail;
    rng_trigger_d = (state_d == ST_TRIG);
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    seg_idx     = seg_idx_q;
    rng_trigger = rng_trigger_q;
    food_x      = food_x_q;
    food_y      = food_y_q;
    food_valid  = food_valid_q;
    placed      = placed_q;
    place_fail  = place_fail_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_food_placer.sv
// ============================================================================
// Module  : tb_food_placer
// Brief   : Directed self-checking bench for food_placer with a behavioural
//           random_position stand-in and a combinational segment store.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_food_placer;

  logic       clk = 1'b0;
  logic       reset;
  logic       place_req;
  logic [4:0] snake_len;
  logic [3:0] seg_idx;
  logic [9:0] seg_x, seg_y;
  logic       rng_trigger;
  logic [9:0] rng_x = 10'd0;
  logic [9:0] rng_y = 10'd0;
  logic [9:0] food_x, food_y;
  logic       food_valid, busy, placed, place_fail;

  logic [9:0]  mem_x [16];
  logic [9:0]  mem_y [16];
  logic [19:0] rng_fifo [$];

  int trig_cnt   = 0;
  int placed_cnt = 0;
  int checks     = 0;
  int errors     = 0;
  int n;
  int t0;
  int p0;

  food_placer dut (
    .clk        (clk),
    .reset      (reset),
    .place_req  (place_req),
    .snake_len  (snake_len),
    .seg_idx    (seg_idx),
    .seg_x      (seg_x),
    .seg_y      (seg_y),
    .rng_trigger(rng_trigger),
    .rng_x      (rng_x),
    .rng_y      (rng_y),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_valid (food_valid),
    .busy       (busy),
    .placed     (placed),
    .place_fail (place_fail)
  );

  always #5 clk = ~clk;

  assign seg_x = mem_x[seg_idx];
  assign seg_y = mem_y[seg_idx];

  // random_position stand-in: a new sample appears on the edge that sees the trigger.
  always @(posedge clk) begin
    if (rng_trigger) begin
      trig_cnt++;
      if (rng_fifo.size() > 0) {rng_x, rng_y} <= rng_fifo.pop_front();
    end
    if (placed) placed_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_req();
    place_req = 1'b1;
    @(negedge clk);
    place_req = 1'b0;
  endtask

  task automatic wait_placed(input int limit, output int edges);
    edges = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (placed) begin
        edges = i;
        return;
      end
    end
  endtask

  task automatic load_body();
    for (int i = 0; i < 16; i++) begin
      mem_x[i] = 10'd0;
      mem_y[i] = 10'd0;
    end
    mem_x[0] = 10'd16; mem_y[0] = 10'd16;
    mem_x[1] = 10'd32; mem_y[1] = 10'd16;
    mem_x[2] = 10'd48; mem_y[2] = 10'd16;
    mem_x[3] = 10'd64; mem_y[3] = 10'd16;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    place_req = 1'b0;
    snake_len = 5'd0;
    load_body();

    // Reset values
    @(negedge clk);
    chk("rst_flags", {27'd0, busy, food_valid, placed, place_fail, rng_trigger}, 32'd0);
    chk("rst_seg_idx", 32'(seg_idx), 32'd0);
    chk("rst_food", {12'd0, food_x, food_y}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Empty snake: commit two edges after the request
    rng_fifo.push_back({10'd137, 10'd205});
    snake_len = 5'd0;
    t0 = trig_cnt;
    start_req();
    chk("A_trig_hi", 32'(rng_trigger), 32'd1);
    chk("A_busy", 32'(busy), 32'd1);
    wait_placed(20, n);
    chk("A_latency", n, 32'd2);
    chk("A_food_x", 32'(food_x), 32'd128);
    chk("A_food_y", 32'(food_y), 32'd192);
    chk("A_valid", 32'(food_valid), 32'd1);
    chk("A_fail", 32'(place_fail), 32'd0);
    @(negedge clk);
    chk("A_placed_pulse", 32'(placed), 32'd0);
    chk("A_trig_count", trig_cnt - t0, 32'd1);
    chk("A_idle", 32'(busy), 32'd0);

    // Four segments, no collision
    rng_fifo.push_back({10'd100, 10'd300});
    snake_len = 5'd4;
    start_req();
    chk("B_valid_drop", 32'(food_valid), 32'd0);
    chk("B_food_hold", 32'(food_x), 32'd128);
    wait_placed(20, n);
    chk("B_latency", n, 32'd6);
    chk("B_food_x", 32'(food_x), 32'd96);
    chk("B_food_y", 32'(food_y), 32'd288);
    chk("B_fail", 32'(place_fail), 32'd0);
    @(negedge clk);

    // Asynchronous reset while scanning segment 3
    rng_fifo.push_back({10'd100, 10'd300});
    start_req();
    repeat (5) @(negedge clk);
    chk("C_seg_idx", 32'(seg_idx), 32'd3);
    chk("C_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("C_rst_flags", {27'd0, busy, food_valid, placed, place_fail, rng_trigger}, 32'd0);
    chk("C_rst_seg_idx", 32'(seg_idx), 32'd0);
    chk("C_rst_food", {12'd0, food_x, food_y}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Collision on segment 2, then a clean second sample
    mem_x[2] = 10'd32; mem_y[2] = 10'd32;
    rng_fifo.push_back({10'd40, 10'd40});
    rng_fifo.push_back({10'd200, 10'd100});
    t0 = trig_cnt;
    start_req();
    repeat (4) @(negedge clk);
    chk("D_seg_idx", 32'(seg_idx), 32'd2);
    chk("D_trig_lo", 32'(rng_trigger), 32'd0);
    @(negedge clk);
    chk("D_retrig", 32'(rng_trigger), 32'd1);
    wait_placed(30, n);
    chk("D_latency", n, 32'd6);
    chk("D_food_x", 32'(food_x), 32'd192);
    chk("D_food_y", 32'(food_y), 32'd96);
    chk("D_fail", 32'(place_fail), 32'd0);
    @(negedge clk);
    chk("D_trig_count", trig_cnt - t0, 32'd2);

    // Every candidate collides: forced commit after seven retries
    for (int i = 0; i < 4; i++) begin
      mem_x[i] = 10'd32;
      mem_y[i] = 10'd32;
    end
    for (int i = 0; i < 8; i++) rng_fifo.push_back({10'd40, 10'd40});
    t0 = trig_cnt;
    start_req();
    wait_placed(100, n);
    chk("E_latency", n, 32'd24);
    chk("E_fail", 32'(place_fail), 32'd1);
    chk("E_valid", 32'(food_valid), 32'd1);
    chk("E_food", {12'd0, food_x, food_y}, {12'd0, 10'd32, 10'd32});
    @(negedge clk);
    chk("E_trig_count", trig_cnt - t0, 32'd8);
    chk("E_fail_pulse", 32'(place_fail), 32'd0);

    // place_req held high: ignored while busy, restarts only from IDLE
    load_body();
    rng_fifo.push_back({10'd100, 10'd300});
    rng_fifo.push_back({10'd100, 10'd300});
    t0 = trig_cnt;
    p0 = placed_cnt;
    place_req = 1'b1;
    @(negedge clk);
    wait_placed(20, n);
    chk("F_latency", n, 32'd6);
    chk("F_no_retrig", trig_cnt - t0, 32'd1);
    place_req = 1'b0;
    @(negedge clk);
    chk("F_idle", 32'(busy), 32'd0);
    chk("F_one_place", placed_cnt - p0, 32'd1);
    place_req = 1'b1;
    @(negedge clk);
    place_req = 1'b0;
    chk("F_restart_busy", 32'(busy), 32'd1);
    chk("F_restart_trig", 32'(rng_trigger), 32'd1);
    wait_placed(20, n);
    chk("F_second_latency", n, 32'd6);
    chk("F_second_food", {12'd0, food_x, food_y}, {12'd0, 10'd96, 10'd288});
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/food_placer.md
Name: food_placer

Overview:
Sequences the food-position generator (random_position) and checks each candidate against the snake body. On a placement request it pulses the generator trigger, captures and tile-aligns the candidate, then scans the snake segment store for a collision. If it collides it retries; if not it commits the food position. It sits between the game FSM, the snake segment store and random_position, and its outputs feed the VGA renderer.

Parameters:
BIT, 10, pixel coordinate width (matches random_position)
MAX_LEN, 16, maximum snake segments scanned
IDX_W, 4, segment index width; must satisfy 2**IDX_W >= MAX_LEN
TILE_LOG2, 4, tile size is 2**TILE_LOG2 pixels; candidates are aligned down to the tile
MAX_RETRY, 7, collisions tolerated before a forced commit

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
place_req  in  1  request new food; sampled in IDLE only
snake_len  in  IDX_W+1  current segment count; values above MAX_LEN are clamped to MAX_LEN
seg_idx  out  IDX_W  segment read address to the segment store
seg_x  in  BIT  segment x at seg_idx (combinational read, same cycle)
seg_y  in  BIT  segment y at seg_idx
rng_trigger  out  1  to random_position new_number_trigger; registered
rng_x  in  BIT  random_position x_out
rng_y  in  BIT  random_position y_out
food_x  out  BIT  committed food x, tile-aligned
food_y  out  BIT  committed food y, tile-aligned
food_valid  out  1  committed food position is valid
busy  out  1  high in every state except IDLE
placed  out  1  one-cycle pulse on commit
place_fail  out  1  one-cycle pulse, coincident with placed, on a forced commit

Behaviour:
- Reset (async, any state): state=IDLE; food_x=0, food_y=0; food_valid=0, busy=0, placed=0, place_fail=0, rng_trigger=0; seg_idx=0; retry count=0.
- States: IDLE, TRIG, LATCH, SCAN.
- IDLE: when place_req=1 at an edge, go to TRIG, clear food_valid, clear retry count. place_req while busy is ignored; it is not queued.
- TRIG: rng_trigger=1 for exactly this cycle, then go to LATCH.
- rng_trigger is low for at least 2 cycles between retries, which guarantees random_position sees a fresh rising edge.
- LATCH: rng_x/rng_y already hold the new sample, because random_position updates at the TRIG edge. Capture cand = {rng[BIT-1:TILE_LOG2], TILE_LOG2 zeros} for x and y. Set seg_idx=0.
  - If clamped snake_len=0, commit at this edge.
  - Otherwise go to SCAN.
- SCAN: each cycle compare seg_x==cand_x && seg_y==cand_y on the full BIT width.
  - Match: if retry count < MAX_RETRY, increment it and go to TRIG. Otherwise force a commit with place_fail=1.
  - No match and seg_idx==len-1: commit.
  - No match otherwise: increment seg_idx.
- Commit: food_x/food_y<=cand, food_valid<=1, placed<=1 for one cycle, state returns to IDLE.
- Latency: with N segments and no collision, a request sampled at edge E0 commits at edge E(N+2); outputs are visible after that edge. A retry after a collision at index k costs k+3 cycles.
- food_x/food_y hold their last committed value until the next commit. Only food_valid drops during placement.
- seg_idx is a don't-care outside SCAN, but is kept stable.
- No arithmetic overflow is possible: retry count is sized for MAX_RETRY, seg_idx never exceeds MAX_LEN-1.

Decomposition:
- Shared package/header snake_defs: TILE_LOG2, BIT, MAX_LEN, IDX_W and the state encoding (2 bits: IDLE=0, TRIG=1, LATCH=2, SCAN=3).
- No sub-module is needed; the tile-align and compare logic is inline.
- random_position is instantiated beside this block at the top level, not inside it.

Test Plan:
- Reset mid-SCAN (assert during seg_idx=3): all outputs return to reset values immediately, without waiting for a clock edge; state IDLE; food_valid=0.
- snake_len=0, rng=(137,205): placed pulses 2 cycles after req; food=(128,192); food_valid=1; rng_trigger high exactly 1 cycle.
- snake_len=4, segments (16,16),(32,16),(48,16),(64,16), rng=(100,300): placed at E6; food=(96,288); place_fail=0.
- rng first yields (40,40) aligning to (32,32), which equals segment 2. The bench checks rng_trigger re-pulses after the SCAN edge at seg_idx=2; the second sample (200,100) commits (192,96).
- Segment store forced to always collide: exactly 8 rng_trigger pulses (1 initial + 7 retries), then placed=1 and place_fail=1 together, food_valid=1.
- place_req held high through a placement: exactly one placement completes while busy, and the next starts only from IDLE.
